shift_dispatcher: RTL and testbench

//  Upstream/downstream sequencer for the iterative Shifter: buffers shift/rotate commands in a FIFO,

---
 rtl/shift_dispatcher.sv | 177 +++++++++++++++++
 tb/tb_shift_dispatcher.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_dispatcher.sv
// Command FIFO and launch sequencer in front of the iterative Shifter, with a valid/ready result slot.
// Optional feature macro: SHIFT_DISPATCH_FASTPATH_EN (large non-rotating shifts skip the Shifter).
module shift_dispatcher #(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    localparam int C    = $clog2(DEPTH + 1)
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_cmd_valid,
    output logic         o_cmd_ready,
    input  logic [N-1:0] i_cmd_value,
    input  logic [N-1:0] i_cmd_iterations,
    input  logic         i_cmd_direction,
    input  logic         i_cmd_rotate,
    output logic         o_result_valid,
    input  logic         i_result_ready,
    output logic [N-1:0] o_result_value,
    output logic [C-1:0] o_count,
    output logic         o_busy,
    output logic         o_shifter_start,
    output logic [N-1:0] o_shifter_value,
    output logic [N-1:0] o_shifter_iterations,
    output logic         o_shifter_direction,
    output logic         o_shifter_rotate,
    input  logic         i_shifter_finished,
    input  logic [N-1:0] i_shifter_value
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = 2 * N + 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [C-1:0]  count;
    logic [CW-1:0] head;
    logic [N-1:0]  head_value, head_iterations;
    logic          head_direction, head_rotate;
    logic          push, launch, capture, result_pop;
    logic [N-1:0]  capture_value;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head            = fifo_mem[rd_ptr];
    assign head_value      = head[N-1:0];
    assign head_iterations = head[2*N-1:N];
    assign head_direction  = head[2*N];
    assign head_rotate     = head[2*N+1];

    assign o_cmd_ready     = (count != C'(DEPTH));
    assign o_count         = count;
    assign o_busy          = (state != S_IDLE);
    assign o_shifter_start = (state == S_LAUNCH);
    assign push            = i_cmd_valid && o_cmd_ready;
    assign result_pop      = o_result_valid && i_result_ready;

`ifdef SHIFT_DISPATCH_FASTPATH_EN
    logic head_fast;
    // A plain shift by N or more always yields zero, so the Shifter is not needed.
    assign head_fast = !head_rotate && ({1'b0, head_iterations} >= (N + 1)'(N));
`endif

    always_ff @(posedge i_clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {i_cmd_rotate, i_cmd_direction, i_cmd_iterations, i_cmd_value};
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (launch) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !launch) begin
                count <= count + 1'b1;
            end else if (!push && launch) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        launch        = 1'b0;
        capture       = 1'b0;
        capture_value = i_shifter_value;
        case (state)
            S_IDLE: begin
                // Single result slot: launch only when it is empty or draining this edge.
                if ((count != '0) && (!o_result_valid || result_pop)) begin
                    launch = 1'b1;
`ifdef SHIFT_DISPATCH_FASTPATH_EN
                    state_next = head_fast ? S_DONE : S_LAUNCH;
`else
                    state_next = S_LAUNCH;
`endif
                end
            end
            S_LAUNCH: begin
                if (i_shifter_finished) begin
                    capture    = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (i_shifter_finished) begin
                    capture    = 1'b1;
                    state_next = S_IDLE;
                end
            end
`ifdef SHIFT_DISPATCH_FASTPATH_EN
            S_DONE: begin
                capture       = 1'b1;
                capture_value = '0;
                state_next    = S_IDLE;
            end
`endif
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_shifter_value      <= '0;
            o_shifter_iterations <= '0;
            o_shifter_direction  <= 1'b0;
            o_shifter_rotate     <= 1'b0;
        end else if (launch) begin
            o_shifter_value      <= head_value;
            o_shifter_iterations <= head_iterations;
            o_shifter_direction  <= head_direction;
            o_shifter_rotate     <= head_rotate;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_result_valid <= 1'b0;
            o_result_value <= '0;
        end else if (capture) begin
            o_result_valid <= 1'b1;
            o_result_value <= capture_value;
        end else if (result_pop) begin
            o_result_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_dispatcher.sv
// Randomized bench for shift_dispatcher: a bit-serial Shifter stand-in plus a queue-based reference model.
module tb_shift_dispatcher;

    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int C     = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [N-1:0] v;
        logic [N-1:0] it;
        logic         dir;
        logic         rot;
    } cmd_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [N-1:0] cmd_value = '0;
    logic [N-1:0] cmd_iter = '0;
    logic         cmd_dir = 1'b0;
    logic         cmd_rot = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [N-1:0] res_value;
    logic [C-1:0] count;
    logic         busy;
    logic         sh_start;
    logic [N-1:0] sh_v, sh_it;
    logic         sh_dir, sh_rot;
    logic         sh_fin;
    logic [N-1:0] sh_out;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    shift_dispatcher #(.N(N), .DEPTH(DEPTH)) dut (
        .i_clock(clk),
        .i_reset(rst),
        .i_cmd_valid(cmd_valid),
        .o_cmd_ready(cmd_ready),
        .i_cmd_value(cmd_value),
        .i_cmd_iterations(cmd_iter),
        .i_cmd_direction(cmd_dir),
        .i_cmd_rotate(cmd_rot),
        .o_result_valid(res_valid),
        .i_result_ready(res_ready),
        .o_result_value(res_value),
        .o_count(count),
        .o_busy(busy),
        .o_shifter_start(sh_start),
        .o_shifter_value(sh_v),
        .o_shifter_iterations(sh_it),
        .o_shifter_direction(sh_dir),
        .o_shifter_rotate(sh_rot),
        .i_shifter_finished(sh_fin),
        .i_shifter_value(sh_out)
    );

    // Shifter stand-in: one bit position per cycle, zero iterations finish combinationally,
    // and the finished line glitches at random while the Shifter is idle.
    logic         glitch = 1'b0;
    logic [N-1:0] glitch_val = '0;
    logic         run;
    logic [N-1:0] run_val, run_rem;

    function automatic logic [N-1:0] step1(input logic [N-1:0] v, input logic dir, input logic rot);
        if (dir) return {v[N-2:0], rot ? v[N-1] : 1'b0};
        else     return {rot ? v[0] : 1'b0, v[N-1:1]};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run     <= 1'b0;
            run_val <= '0;
            run_rem <= '0;
        end else if (sh_start) begin
            if (sh_it != '0) begin
                run     <= 1'b1;
                run_val <= step1(sh_v, sh_dir, sh_rot);
                run_rem <= sh_it - 1'b1;
            end
        end else if (run) begin
            if (run_rem == '0) begin
                run <= 1'b0;
            end else begin
                run_val <= step1(run_val, sh_dir, sh_rot);
                run_rem <= run_rem - 1'b1;
            end
        end
    end

    always_comb begin
        sh_fin = glitch;
        sh_out = glitch_val;
        if (sh_start) begin
            sh_fin = (sh_it == '0);
            sh_out = (sh_it == '0) ? sh_v : glitch_val;
        end else if (run) begin
            sh_fin = (run_rem == '0);
            sh_out = run_val;
        end
    end

    // Reference: the arithmetic meaning of a command.
    function automatic logic [N-1:0] ref_result(input cmd_t c);
        int x, k, r;
        x = int'(c.v);
        if (c.rot) begin
            k = int'(c.it) % N;
            if (c.dir) r = (x << k) | (x >> (N - k));
            else       r = (x >> k) | (x << (N - k));
        end else if (int'(c.it) >= N) begin
            r = 0;
        end else begin
            r = c.dir ? (x << c.it) : (x >> c.it);
        end
        return N'(r);
    endfunction

    function automatic logic is_fast(input cmd_t c);
`ifdef SHIFT_DISPATCH_FASTPATH_EN
        return !c.rot && (int'(c.it) >= N);
`else
        return (c.rot && !c.rot);
`endif
    endfunction

    // Transaction-level model of the dispatcher.
    cmd_t         q[$];
    cmd_t         cur_m;
    logic         busy_m = 1'b0;
    logic         first_m = 1'b0;
    int           left_m = 0;
    logic         rv_m = 1'b0;
    logic [N-1:0] rval_m = '0;
    int           delivered = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        busy_m  = 1'b0;
        first_m = 1'b0;
        left_m  = 0;
        rv_m    = 1'b0;
        rval_m  = '0;
    endtask

    task automatic model_step();
        logic rpop, do_launch, was_busy;
        int   old_size;
        cmd_t c;
        rpop      = rv_m && res_ready;
        was_busy  = busy_m;
        old_size  = q.size();
        do_launch = !was_busy && (old_size > 0) && (!rv_m || rpop);
        if (rpop) delivered++;
        first_m = 1'b0;
        if (was_busy) begin
            if (left_m == 0) begin
                busy_m = 1'b0;
                rv_m   = 1'b1;
                rval_m = ref_result(cur_m);
            end else begin
                left_m--;
                if (rpop) rv_m = 1'b0;
            end
        end else if (rpop) begin
            rv_m = 1'b0;
        end
        if (do_launch) begin
            cur_m   = q.pop_front();
            busy_m  = 1'b1;
            first_m = 1'b1;
            left_m  = is_fast(cur_m) ? 0 : int'(cur_m.it);
        end
        if (cmd_valid && (old_size != DEPTH)) begin
            c.v = cmd_value; c.it = cmd_iter; c.dir = cmd_dir; c.rot = cmd_rot;
            q.push_back(c);
        end
    endtask

    task automatic compare();
        chk("cmd_ready", cmd_ready, q.size() != DEPTH);
        chk("count", count, q.size());
        chk("busy", busy, busy_m);
        chk("start", sh_start, busy_m && first_m && !is_fast(cur_m));
        chk("res_valid", res_valid, rv_m);
        chk("res_value", res_value, rval_m);
        if (busy_m && !is_fast(cur_m)) begin
            chk("op_value", sh_v, cur_m.v);
            chk("op_iter", sh_it, cur_m.it);
            chk("op_dir", sh_dir, cur_m.dir);
            chk("op_rot", sh_rot, cur_m.rot);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_step();
        #1;
        glitch     = 1'($urandom_range(0, 1));
        glitch_val = N'($urandom);
    endtask

    task automatic push_cmd(input logic [N-1:0] v, input logic [N-1:0] it, input logic dir, input logic rot);
        cmd_value = v; cmd_iter = it; cmd_dir = dir; cmd_rot = rot; cmd_valid = 1'b1;
        cycle();
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((busy_m || q.size() != 0 || rv_m) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_timeout", (busy_m || q.size() != 0 || rv_m), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_value"}, res_value, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_start"}, sh_start, 0);
        chk({tag, "_op_value"}, sh_v, 0);
        chk({tag, "_op_iter"}, sh_it, 0);
    endtask

    initial begin
        cmd_t lit;
        lit = '{v: 8'h81, it: 8'd1, dir: 1'b1, rot: 1'b0};
        chk("ref_shl_81", ref_result(lit), 8'h02);
        lit = '{v: 8'h01, it: 8'd3, dir: 1'b0, rot: 1'b1};
        chk("ref_ror_01", ref_result(lit), 8'h20);
        lit = '{v: 8'hA5, it: 8'd8, dir: 1'b1, rot: 1'b1};
        chk("ref_rol_a5", ref_result(lit), 8'hA5);
        lit = '{v: 8'h3C, it: 8'd0, dir: 1'b0, rot: 1'b0};
        chk("ref_it0", ref_result(lit), 8'h3C);
        lit = '{v: 8'hFF, it: 8'd9, dir: 1'b1, rot: 1'b0};
        chk("ref_shl_big", ref_result(lit), 8'h00);

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b0;
        res_ready = 1'b1;

        // Directed commands from the specification, each run to completion.
        push_cmd(8'h81, 8'd1, 1'b1, 1'b0); drain(50);
        push_cmd(8'h01, 8'd3, 1'b0, 1'b1); drain(50);
        push_cmd(8'hA5, 8'd8, 1'b1, 1'b1); drain(50);
        push_cmd(8'h3C, 8'd0, 1'b0, 1'b0); drain(50);
        push_cmd(8'hFF, 8'd9, 1'b1, 1'b0); drain(50);

        // Backpressure: one command held in the result slot, four queued, the sixth refused.
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push_cmd(N'(8'h11 * (i + 1)), N'(i % 3), i[0], i[1]);
        end
        repeat (12) cycle();
        chk("bp_count", count, 4);
        chk("bp_cmd_ready", cmd_ready, 0);
        chk("bp_res_valid", res_valid, 1);
        delivered = 0;
        res_ready = 1'b1;
        drain(200);
        chk("bp_delivered", delivered, 5);

        // Randomized traffic with random consumer stalls.
        for (int i = 0; i < 1500; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_value = N'($urandom);
            cmd_iter  = ($urandom_range(0, 9) == 0) ? N'($urandom_range(0, 255)) : N'($urandom_range(0, 10));
            cmd_dir   = 1'($urandom_range(0, 1));
            cmd_rot   = 1'($urandom_range(0, 1));
            res_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        drain(3000);

        // Reset while a long command runs with two more queued.
        push_cmd(8'h5A, 8'd30, 1'b1, 1'b1);
        push_cmd(8'h5B, 8'd30, 1'b0, 1'b1);
        push_cmd(8'h5C, 8'd30, 1'b1, 1'b0);
        repeat (4) cycle();
        chk("mid_count", count, 2);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        model_reset();
        #1;
        rst = 1'b0;
        repeat (60) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
